mem_stg: RTL
============

# mem_stg

Memory stage of the five-stage MIPS pipeline. It is the consumer of the exec_mem valid/ready interface: it captures one execute result packet at a time and performs any load or store on a single-outstanding data-memory port. Load data is aligned and extended, stores get byte enables, and jump redirects are raised toward fetch. Results go to writeback on a mem_wb valid/ready interface, and destination and forwarding data go to the hazard unit.

## Interface
- No parameters; widths come from mips_pkg (word_t 32b, reg_t 5b).

Ports (clock and reset first):
- clk  in  1  pipeline clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- exec_mem_vld  in  1  execute packet valid
- exec_mem_rdy  out  1  stage can accept a packet this cycle
- exec_mem_pkt  in  exec_mem_pkt_t  jmp_vld, addr, mem_op, mem_sz, sgnd, dst_vld, dst_reg, data (data = store data for MEM_ST, result otherwise)
- mem_wb_vld  out  1  writeback packet valid
- mem_wb_rdy  in  1  writeback accepts
- mem_wb_pkt  out  mem_wb_pkt_t  dst_vld, dst_reg, data
- dmem_req_vld  out  1  data-memory request valid
- dmem_req_rdy  in  1  data memory accepts request
- dmem_req_we  out  1  1 = store
- dmem_req_addr  out  32  {addr[31:2],2'b00}
- dmem_req_be  out  4  byte enables, bit i = byte lane i (little-endian)
- dmem_req_wdata  out  32  lane-replicated store data
- dmem_rsp_vld  in  1  load data valid (one cycle)
- dmem_rsp_data  in  32  load word
- mem_fetch_jmp_vld  out  1  redirect pulse
- mem_fetch_jmp_addr  out  32  redirect target
- mem_haz_pkt  out  haz_pkg::mem_haz_pkt_t  dst_vld, dst_reg, data_vld, data

## Operation
- State: in_pkt_q plus FSM {EMPTY, REQ, WAIT, DONE}; result register res_q (32b).
- exec_mem_rdy = (state==EMPTY) | (mem_wb_vld & mem_wb_rdy).
- Capture (exec_mem_vld & exec_mem_rdy): in_pkt_q <= pkt; next state = REQ if mem_op != NO_MEM_OP, else DONE with res_q <= pkt.data.
- REQ: dmem_req_vld=1. On dmem_req_rdy, a store goes to DONE (res_q unchanged, dst_vld expected 0) and a load goes to WAIT. Request fields stay stable while vld & ~rdy.
- WAIT: on dmem_rsp_vld, res_q <= extracted load data, then DONE. dmem_rsp_vld outside WAIT is ignored.
- DONE: mem_wb_vld=1. On mem_wb_rdy, go to the state set by a simultaneous capture, else EMPTY.
- Store encode (lane = addr[1:0]):
  - MEM_B: be = 1<<lane, wdata = {4{data[7:0]}}.
  - MEM_H: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{data[15:0]}}.
  - MEM_W: be = 4'b1111, wdata = data.
- Load extract:
  - MEM_B: byte at lane.
  - MEM_H: halfword at addr[1].
  - MEM_W: full word.
  - Sign-extend if sgnd, else zero-extend.
- Misalignment is not trapped: unused low address bits are ignored.
- mem_wb_pkt = {in_pkt_q.dst_vld, in_pkt_q.dst_reg, res_q}.
- mem_fetch_jmp_vld = in_pkt_q.jmp_vld & mem_wb_vld & mem_wb_rdy, so it pulses exactly once per jump packet. mem_fetch_jmp_addr = in_pkt_q.addr.
- mem_haz_pkt:
  - dst_vld = (state!=EMPTY) & in_pkt_q.dst_vld
  - dst_reg = in_pkt_q.dst_reg
  - data_vld = (state==DONE)
  - data = res_q

## Timing
- Reset (async, resetn=0): state EMPTY, in_pkt_q=0, res_q=0. Outputs are then:
  - exec_mem_rdy=1
  - all vld outputs, dmem_req_*, mem_wb_pkt, mem_fetch_* and mem_haz_pkt = 0
- Reset mid-REQ or mid-WAIT abandons the access. A late dmem_rsp_vld after reset is ignored.
- Non-memory packet: mem_wb_vld the cycle after capture. Sustains 1 packet/cycle with mem_wb_rdy=1.
- Store: earliest mem_wb_vld 2 cycles after capture (REQ accepted in the first cycle).
- Load: mem_wb_vld the cycle after dmem_rsp_vld. Earliest is 3 cycles after capture, with the response the cycle after acceptance.
- dmem_req_vld must not depend combinationally on dmem_req_rdy.
- When mem_wb_rdy=0 in DONE, all outputs hold and exec_mem_rdy=0.

## Test plan
- ALU pass-through: data=0x1234_5678, dst_reg=5, mem_rdy=1 -> mem_wb_pkt {1,5,0x12345678} one cycle later; 4 back-to-back packets retire in 4 consecutive cycles.
- Signed byte load, addr=0x103, rsp_data=0x80FF_FF00 -> dmem_req_addr=0x100, be=0, we=0; wb data=0xFFFF_FF80. Same load with sgnd=0 -> 0x0000_0080.
- Store half, addr=0x202, data=0xABCD_1234, dmem_req_rdy low for 2 cycles -> be=1100 and wdata=0x1234_1234 held stable for 3 cycles; mem_wb_vld the cycle after acceptance.
- Load word with response latency 3 and mem_wb_rdy low for 2 cycles -> exec_mem_rdy=0 throughout; mem_haz_pkt.data_vld=0 until DONE; a single wb handshake occurs.
- Jump packet with jmp_vld=1, addr=0x0040_0020 -> mem_fetch_jmp_vld is a 1-cycle pulse with addr 0x00400020, coincident with the wb handshake.
- Reset asserted in WAIT, followed by a stray dmem_rsp_vld -> all outputs 0, state EMPTY, no wb packet.

Source files
------------

// File: rtl/mem_stg.sv
// mem_stg: memory stage of the five-stage MIPS pipeline.
//
// Holds one execute result packet at a time. Non-memory packets go straight
// to writeback the cycle after capture. Loads and stores go through a
// single-outstanding data-memory port: the request is presented, then stores
// retire immediately while loads wait for the response word, which is
// aligned and sign/zero-extended. Jump packets raise a one-cycle redirect
// toward fetch at the moment they hand off to writeback.
//
// Ports:
//   clk, resetn          pipeline clock / async active-low reset
//   exec_mem_*           valid/ready input from execute (one packet)
//   mem_wb_*             valid/ready output to writeback
//   dmem_req_*           data-memory request (addr word-aligned, byte enables)
//   dmem_rsp_*           data-memory load response (one-cycle pulse)
//   mem_fetch_jmp_*      redirect pulse and target toward fetch
//   mem_haz_pkt          destination / forwarding info for the hazard unit

package mips_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_t;

  typedef enum logic [1:0] {
    NO_MEM_OP = 2'd0,
    MEM_LD    = 2'd1,
    MEM_ST    = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_sz_t;

  typedef struct packed {
    logic    jmp_vld;
    word_t   addr;
    mem_op_t mem_op;
    mem_sz_t mem_sz;
    logic    sgnd;
    logic    dst_vld;
    reg_t    dst_reg;
    word_t   data;
  } exec_mem_pkt_t;

  typedef struct packed {
    logic  dst_vld;
    reg_t  dst_reg;
    word_t data;
  } mem_wb_pkt_t;
endpackage

package haz_pkg;
  typedef struct packed {
    logic           dst_vld;
    mips_pkg::reg_t dst_reg;
    logic           data_vld;
    mips_pkg::word_t data;
  } mem_haz_pkt_t;
endpackage

module mem_stg
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  exec_mem_vld,
  output logic                  exec_mem_rdy,
  input  exec_mem_pkt_t         exec_mem_pkt,
  output logic                  mem_wb_vld,
  input  logic                  mem_wb_rdy,
  output mem_wb_pkt_t           mem_wb_pkt,
  output logic                  dmem_req_vld,
  input  logic                  dmem_req_rdy,
  output logic                  dmem_req_we,
  output logic [31:0]           dmem_req_addr,
  output logic [3:0]            dmem_req_be,
  output logic [31:0]           dmem_req_wdata,
  input  logic                  dmem_rsp_vld,
  input  logic [31:0]           dmem_rsp_data,
  output logic                  mem_fetch_jmp_vld,
  output logic [31:0]           mem_fetch_jmp_addr,
  output haz_pkg::mem_haz_pkt_t mem_haz_pkt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  state_t        cap_state;
  exec_mem_pkt_t in_pkt_q;
  word_t         res_q;
  word_t         load_data;
  logic          capture;
  logic          wb_hs;
  logic          is_store;
  logic [1:0]    lane;
  logic [7:0]    rsp_byte;
  logic [15:0]   rsp_half;
  logic [3:0]    st_be;
  word_t         st_wdata;

  // Handshake terms. A new packet may enter while the current one is leaving,
  // which is what lets non-memory traffic stream at one packet per cycle.
  assign mem_wb_vld   = (state == DONE);
  assign dmem_req_vld = (state == REQ);
  assign wb_hs        = mem_wb_vld & mem_wb_rdy;
  assign exec_mem_rdy = (state == EMPTY) | wb_hs;
  assign capture      = exec_mem_vld & exec_mem_rdy;
  assign cap_state    = (exec_mem_pkt.mem_op != NO_MEM_OP) ? REQ : DONE;

  // State, packet and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= EMPTY;
      in_pkt_q <= '0;
      res_q    <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        in_pkt_q <= exec_mem_pkt;
      end
      if (capture && (exec_mem_pkt.mem_op == NO_MEM_OP)) begin
        res_q <= exec_mem_pkt.data;
      end else if ((state == WAIT) && dmem_rsp_vld) begin
        res_q <= load_data;
      end
    end
  end

  // Next-state logic. The request valid is a pure function of state, so it
  // never combinationally depends on dmem_req_rdy.
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: begin
        if (capture) state_nxt = cap_state;
      end
      REQ: begin
        if (dmem_req_rdy) state_nxt = is_store ? DONE : WAIT;
      end
      WAIT: begin
        if (dmem_rsp_vld) state_nxt = DONE;
      end
      DONE: begin
        if (mem_wb_rdy) state_nxt = capture ? cap_state : EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign is_store = (in_pkt_q.mem_op == MEM_ST);
  assign lane     = in_pkt_q.addr[1:0];

  // Load extraction: pick the addressed byte/halfword and extend it.
  // Misaligned halfword/word accesses simply ignore the unused low bits.
  always_comb begin
    rsp_byte  = 8'h00;
    rsp_half  = 16'h0000;
    load_data = dmem_rsp_data;
    unique case (lane)
      2'd0: rsp_byte = dmem_rsp_data[7:0];
      2'd1: rsp_byte = dmem_rsp_data[15:8];
      2'd2: rsp_byte = dmem_rsp_data[23:16];
      2'd3: rsp_byte = dmem_rsp_data[31:24];
      default: rsp_byte = 8'h00;
    endcase
    rsp_half = lane[1] ? dmem_rsp_data[31:16] : dmem_rsp_data[15:0];
    case (in_pkt_q.mem_sz)
      MEM_B:   load_data = in_pkt_q.sgnd ? {{24{rsp_byte[7]}}, rsp_byte}
                                         : {24'h000000, rsp_byte};
      MEM_H:   load_data = in_pkt_q.sgnd ? {{16{rsp_half[15]}}, rsp_half}
                                         : {16'h0000, rsp_half};
      default: load_data = dmem_rsp_data;
    endcase
  end

  // Store encoding: data is replicated across lanes so the memory only has
  // to honour the byte enables.
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = '0;
    case (in_pkt_q.mem_sz)
      MEM_B: begin
        st_be    = 4'b0001 << lane;
        st_wdata = {4{in_pkt_q.data[7:0]}};
      end
      MEM_H: begin
        st_be    = lane[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{in_pkt_q.data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = in_pkt_q.data;
      end
    endcase
  end

  // Request fields come straight from the held packet, so they stay stable
  // for as long as the request is stalled.
  assign dmem_req_we    = is_store;
  assign dmem_req_addr  = {in_pkt_q.addr[31:2], 2'b00};
  assign dmem_req_be    = is_store ? st_be : 4'b0000;
  assign dmem_req_wdata = is_store ? st_wdata : 32'h0000_0000;

  assign mem_wb_pkt.dst_vld = in_pkt_q.dst_vld;
  assign mem_wb_pkt.dst_reg = in_pkt_q.dst_reg;
  assign mem_wb_pkt.data    = res_q;

  // Redirect fires on the writeback handshake, so a stalled jump packet
  // still produces exactly one pulse.
  assign mem_fetch_jmp_vld  = in_pkt_q.jmp_vld & wb_hs;
  assign mem_fetch_jmp_addr = in_pkt_q.addr;

  assign mem_haz_pkt.dst_vld  = (state != EMPTY) & in_pkt_q.dst_vld;
  assign mem_haz_pkt.dst_reg  = in_pkt_q.dst_reg;
  assign mem_haz_pkt.data_vld = (state == DONE);
  assign mem_haz_pkt.data     = res_q;

endmodule
